display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan_if.sv | 22 ++
 rtl/display_scan.sv | 199 +++++++++++++++++++
 tb/tb_display_scan.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/display_scan_if.sv
// Board-state inputs and row/column drive outputs of the LED-matrix scanner.
// The design side uses the slave modport; whoever supplies game state uses master.
interface display_scan_if;
  logic [255:0] i_body_pos;
  logic [3:0]   i_head_x;
  logic [3:0]   i_head_y;
  logic [7:0]   i_item_loc;
  logic         i_collision;
  logic [15:0]  o_row_sel;
  logic [15:0]  o_col_grn;
  logic [15:0]  o_col_red;
  logic         o_frame_start;

  modport slave (
    input  i_body_pos, i_head_x, i_head_y, i_item_loc, i_collision,
    output o_row_sel, o_col_grn, o_col_red, o_frame_start
  );
  modport master (
    output i_body_pos, i_head_x, i_head_y, i_item_loc, i_collision,
    input  o_row_sel, o_col_grn, o_col_red, o_frame_start
  );
endinterface

// File: rtl/display_scan.sv
// 16x16 two-colour LED matrix row scanner: LOAD/DRIVE/BLANK per row, per-frame input snapshot.
// Optional item blinking is enabled by defining DISPLAY_SCAN_BLINK_EN. i_rst is active-low.
module display_scan_pix (
  input  logic i_body,
  input  logic i_head,
  input  logic i_item,
  input  logic i_collision,
  input  logic i_item_off,
  output logic o_grn,
  output logic o_red
);
  always_comb begin
    o_grn = 1'b0;
    o_red = 1'b0;
    if (i_head) begin
      o_grn = !i_collision;
      o_red = 1'b1;
    end else if (i_item) begin
      o_red = !i_item_off;
    end else if (i_body) begin
      o_grn = 1'b1;
    end
  end
endmodule

module display_scan #(
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic            i_sys_clk,
  input  logic            i_rst,
  display_scan_if.slave   bus
);
  localparam logic [15:0] DWELL_M1 = 16'(DWELL_CYCLES - 1);
  localparam logic [15:0] BLANK_M1 = 16'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {LOAD, DRIVE, BLANK} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_cnt, w_cnt_nxt;
  logic [3:0]  r_row, w_row_nxt;

  always_ff @(posedge i_sys_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= LOAD;
      r_cnt   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_row   <= w_row_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_row_nxt   = r_row;
    case (r_state)
      LOAD: begin
        w_state_nxt = DRIVE;
        w_cnt_nxt   = '0;
      end
      DRIVE: begin
        if (r_cnt == DWELL_M1) begin
          w_state_nxt = BLANK;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      BLANK: begin
        if (r_cnt == BLANK_M1) begin
          w_state_nxt = LOAD;
          w_cnt_nxt   = '0;
          w_row_nxt   = r_row + 4'd1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Row-0 LOAD both snapshots the board and builds row 0 from the live inputs,
  // since the shadow copy only becomes valid after this edge.
  logic         w_snap;
  logic [255:0] r_body;
  logic [3:0]   r_hx, r_hy;
  logic [7:0]   r_item;
  logic         r_coll;
  logic [255:0] w_body;
  logic [3:0]   w_hx, w_hy;
  logic [7:0]   w_item;
  logic         w_coll;
  logic         w_item_off;

  assign w_snap = (r_state == LOAD) && (r_row == 4'd0);

  always_ff @(posedge i_sys_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_body <= '0;
      r_hx   <= '0;
      r_hy   <= '0;
      r_item <= '0;
      r_coll <= 1'b0;
    end else if (w_snap) begin
      r_body <= bus.i_body_pos;
      r_hx   <= bus.i_head_x;
      r_hy   <= bus.i_head_y;
      r_item <= bus.i_item_loc;
      r_coll <= bus.i_collision;
    end
  end

  assign w_body = w_snap ? bus.i_body_pos  : r_body;
  assign w_hx   = w_snap ? bus.i_head_x    : r_hx;
  assign w_hy   = w_snap ? bus.i_head_y    : r_hy;
  assign w_item = w_snap ? bus.i_item_loc  : r_item;
  assign w_coll = w_snap ? bus.i_collision : r_coll;

`ifdef DISPLAY_SCAN_BLINK_EN
  logic [7:0] r_frame_cnt;
  logic       r_item_off;

  // The blink phase is latched with the snapshot so it is constant across a frame.
  always_ff @(posedge i_sys_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_frame_cnt <= '0;
      r_item_off  <= 1'b0;
    end else if (w_snap) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
      r_item_off  <= r_frame_cnt[4];
    end
  end

  assign w_item_off = w_snap ? r_frame_cnt[4] : r_item_off;
`else
  assign w_item_off = 1'b0;
`endif

  logic [15:0] w_grn, w_red;

  for (genvar c = 0; c < 16; c++) begin : g_col
    display_scan_pix u_pix (
      .i_body      (w_body[{4'(c), r_row}]),
      .i_head      ((w_hx == 4'(c)) && (w_hy == r_row)),
      .i_item      ((w_item[7:4] == 4'(c)) && (w_item[3:0] == r_row)),
      .i_collision (w_coll),
      .i_item_off  (w_item_off),
      .o_grn       (w_grn[c]),
      .o_red       (w_red[c])
    );
  end

  logic [15:0] r_col_grn, r_col_red;

  always_ff @(posedge i_sys_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_col_grn <= '0;
      r_col_red <= '0;
    end else if (r_state == LOAD) begin
      r_col_grn <= w_grn;
      r_col_red <= w_red;
    end
  end

  // Output registers show the phase the FSM held during the preceding cycle.
  logic [15:0] r_row_sel, r_out_grn, r_out_red;
  logic        r_frame_start;

  always_ff @(posedge i_sys_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_row_sel     <= '0;
      r_out_grn     <= '0;
      r_out_red     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_snap;
      if (r_state == DRIVE) begin
        r_row_sel <= 16'd1 << r_row;
        r_out_grn <= r_col_grn;
        r_out_red <= r_col_red;
      end else begin
        r_row_sel <= '0;
        r_out_grn <= '0;
        r_out_red <= '0;
      end
    end
  end

  assign bus.o_row_sel     = r_row_sel;
  assign bus.o_col_grn     = r_out_grn;
  assign bus.o_col_red     = r_out_red;
  assign bus.o_frame_start = r_frame_start;
endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan (DWELL=4, BLANK=2): frame-phase model checked every cycle
// plus hand-computed expectations at key cycles.
module tb_display_scan;
  localparam int ROWP  = 7;
  localparam int FRAME = 112;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   k = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  display_scan_if bus ();

  display_scan #(.DWELL_CYCLES(4), .BLANK_CYCLES(2)) dut (
    .i_sys_clk (clk),
    .i_rst     (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  logic [255:0] s_body;
  logic [3:0]   s_hx, s_hy;
  logic [7:0]   s_item;
  logic         s_coll;

  // k = rising edges since reset release; the board is sampled at each frame's first edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k <= 0;
    end else begin
      if (k % FRAME == 0) begin
        s_body <= bus.i_body_pos;
        s_hx   <= bus.i_head_x;
        s_hy   <= bus.i_head_y;
        s_item <= bus.i_item_loc;
        s_coll <= bus.i_collision;
      end
      k <= k + 1;
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30)
        $display("FAIL %s t=%0t k=%0d actual=%h expected=%h", nm, $time, k, act, exp);
    end
  endtask

  function automatic void model(output logic [15:0] rs, output logic [15:0] g,
                                output logic [15:0] r, output logic fs);
    int p, row, q, f;
    logic off;
    rs = '0; g = '0; r = '0; fs = 1'b0;
    if (rst_n && k >= 1) begin
      p   = (k - 1) % FRAME;
      f   = (k - 1) / FRAME;
      row = p / ROWP;
      q   = p % ROWP;
      fs  = (p == 0);
`ifdef DISPLAY_SCAN_BLINK_EN
      off = ((f / 16) % 2) == 1;
`else
      off = 1'b0;
`endif
      if (q >= 1 && q <= 4) begin
        rs = 16'd1 << row;
        for (int c = 0; c < 16; c++) begin
          if (c == int'(s_hx) && row == int'(s_hy)) begin
            g[c] = !s_coll; r[c] = 1'b1;
          end else if (c == int'(s_item[7:4]) && row == int'(s_item[3:0])) begin
            r[c] = !off;
          end else if (s_body[c*16 + row]) begin
            g[c] = 1'b1;
          end
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [15:0] e_rs, e_g, e_r;
    logic        e_fs;
    model(e_rs, e_g, e_r, e_fs);
    chk("model_row_sel", bus.o_row_sel, e_rs);
    chk("model_col_grn", bus.o_col_grn, e_g);
    chk("model_col_red", bus.o_col_red, e_r);
    chk("model_frame_start", {15'd0, bus.o_frame_start}, {15'd0, e_fs});
  end

  task automatic goto(input int n);
    int guard = 0;
    while (k < n && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    chk("goto_reached", 16'(k == n), 16'd1);
  endtask

  initial begin
    bus.i_body_pos  = '0;
    bus.i_body_pos[48] = 1'b1;
    bus.i_body_pos[80] = 1'b1;
    bus.i_head_x    = 4'd8;
    bus.i_head_y    = 4'd4;
    bus.i_item_loc  = 8'h25;
    bus.i_collision = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_row_sel", bus.o_row_sel, 16'h0000);
    chk("reset_frame_start", {15'd0, bus.o_frame_start}, 16'd0);
    #1 rst_n = 1'b1;

    goto(1);  chk("fs_cycle1", {15'd0, bus.o_frame_start}, 16'd1);
              chk("load_row_sel", bus.o_row_sel, 16'h0000);
    goto(2);  chk("row0_sel", bus.o_row_sel, 16'h0001);
              chk("row0_grn", bus.o_col_grn, 16'h0028);
              chk("row0_red", bus.o_col_red, 16'h0000);
    goto(5);  chk("row0_sel_c5", bus.o_row_sel, 16'h0001);
    goto(6);  chk("blank_c6", bus.o_row_sel, 16'h0000);
    goto(8);  chk("row1_load_fs", {15'd0, bus.o_frame_start}, 16'd0);
    goto(9);  chk("row1_sel", bus.o_row_sel, 16'h0002);
    goto(16); bus.i_body_pos[55] = 1'b1;
    goto(30); chk("row4_sel", bus.o_row_sel, 16'h0010);
              chk("row4_grn", bus.o_col_grn, 16'h0100);
              chk("row4_red", bus.o_col_red, 16'h0100);
    goto(37); chk("row5_red", bus.o_col_red, 16'h0004);
              chk("row5_grn", bus.o_col_grn, 16'h0000);
    goto(51); chk("row7_f0_grn", bus.o_col_grn, 16'h0000);
    goto(163); chk("row7_f1_grn", bus.o_col_grn, 16'h0008);
    goto(170); bus.i_collision = 1'b1; bus.i_head_x = 4'd15; bus.i_head_y = 4'd15;
    goto(219); chk("row15_f1_red", bus.o_col_red, 16'h0000);
    goto(331); chk("row15_f2_red", bus.o_col_red, 16'h8000);
               chk("row15_f2_grn", bus.o_col_grn, 16'h0000);

    bus.i_collision = 1'b0; bus.i_head_x = 4'd8; bus.i_head_y = 4'd4;
    goto(401); chk("row9_sel", bus.o_row_sel, 16'h0200);
    #2 rst_n = 1'b0;
    #1 chk("async_row_sel", bus.o_row_sel, 16'h0000);
       chk("async_grn", bus.o_col_grn, 16'h0000);
       chk("async_red", bus.o_col_red, 16'h0000);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    goto(1); chk("restart_fs", {15'd0, bus.o_frame_start}, 16'd1);
    goto(2); chk("restart_row0", bus.o_row_sel, 16'h0001);
             chk("restart_grn", bus.o_col_grn, 16'h0028);
`ifdef DISPLAY_SCAN_BLINK_EN
    goto(15*FRAME + 37); chk("blink_f15", bus.o_col_red, 16'h0004);
    goto(16*FRAME + 37); chk("blink_f16", bus.o_col_red, 16'h0000);
    goto(31*FRAME + 37); chk("blink_f31", bus.o_col_red, 16'h0000);
    goto(32*FRAME + 37); chk("blink_f32", bus.o_col_red, 16'h0004);
`else
    goto(16*FRAME + 37); chk("steady_f16", bus.o_col_red, 16'h0004);
`endif
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
